cache_mem_arbiter: RTL and testbench

- Arbitrates the single multi-cycle main memory between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sits between the two caches and the memory model in the pipelined CPU.
- Sequences each 8-word block fill as a pipelined burst and returns words tagged with an index.
- Signals completion to the requesting cache.

---
 rtl/cache_pkg.sv | 18 +
 rtl/fill_counter.sv | 54 +++++
 rtl/cache_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache <-> main memory arbiter.
package cache_pkg;

  localparam int unsigned WORDS_PER_BLK   = 8;
  localparam int unsigned WORD_IDX_W      = $clog2(WORDS_PER_BLK);
  // 8 words of 2 bytes each: the low 4 address bits select a byte inside the block.
  localparam int unsigned BLK_OFFSET_BITS = 4;
  // Fixed read latency of the memory model, address issue to mem_rvalid.
  localparam int unsigned MEM_LAT         = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_DWRITE,
    ARB_DFILL,
    ARB_IFILL
  } arb_state_e;

endpackage

// File: rtl/fill_counter.sv
// Issue and return word counters for one block fill, shared by both fill states.
module fill_counter
  import cache_pkg::*;
#(
  parameter int unsigned WORDS = WORDS_PER_BLK
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       issue_inc,
  input  logic                       ret_inc,
  output logic [$clog2(WORDS):0]     issue_cnt,
  output logic [$clog2(WORDS)-1:0]   ret_cnt,
  output logic                       issue_done,
  output logic                       ret_last
);

  localparam int unsigned IdxW    = $clog2(WORDS);
  localparam int unsigned LastIdx = WORDS - 1;

  logic [IdxW:0]   issue_q, issue_d;
  logic [IdxW-1:0] ret_q, ret_d;

  assign issue_cnt  = issue_q;
  assign ret_cnt    = ret_q;
  // Issue counter saturates at WORDS so the address phase ends by itself.
  assign issue_done = (issue_q == WORDS[IdxW:0]);
  assign ret_last   = (ret_q == LastIdx[IdxW-1:0]);

  // Next-state for both counters; clear has priority over increment.
  always_comb begin
    issue_d = issue_q;
    ret_d   = ret_q;
    if (clr) begin
      issue_d = '0;
      ret_d   = '0;
    end else begin
      if (issue_inc && !issue_done) issue_d = issue_q + 1'b1;
      if (ret_inc)                  ret_d   = ret_q + 1'b1;
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_q <= '0;
      ret_q   <= '0;
    end else begin
      issue_q <= issue_d;
      ret_q   <= ret_d;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single main memory between D-cache stores, D fills and I fills.
// Fills are issued as a pipelined burst of 8 reads; returned words are tagged
// with their index and the owning side.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_fill_valid,
  output logic              d_fill_valid,
  output logic [2:0]        fill_word,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic                  in_fill;
  logic                  ret_fire;
  logic                  cnt_clr;
  logic [WORD_IDX_W:0]   issue_cnt;
  logic [WORD_IDX_W-1:0] ret_cnt;
  logic                  issue_done;
  logic                  ret_last;
  logic [ADDR_W-1:0]     word_offset;

  assign in_fill  = (state_q == ARB_DFILL) || (state_q == ARB_IFILL);
  // Returns outside a fill state (stale or spurious) never touch the counters.
  assign ret_fire = in_fill && mem_rvalid;
  assign cnt_clr  = !in_fill || (ret_fire && ret_last);
  assign busy     = (state_q != ARB_IDLE);

  // Word k lives at byte offset 2k; the base is block aligned so this never carries.
  assign word_offset = ADDR_W'({issue_cnt[WORD_IDX_W-1:0], 1'b0});

  fill_counter #(
    .WORDS(WORDS_PER_BLK)
  ) u_fill_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .issue_inc (in_fill),
    .ret_inc   (ret_fire),
    .issue_cnt (issue_cnt),
    .ret_cnt   (ret_cnt),
    .issue_done(issue_done),
    .ret_last  (ret_last)
  );

  // Block-offset bits of the miss addresses are dropped by alignment.
  logic unused_bits;
  assign unused_bits = ^{i_miss_addr[BLK_OFFSET_BITS-1:0], d_miss_addr[BLK_OFFSET_BITS-1:0],
                         issue_cnt[WORD_IDX_W]};

  // Fixed-priority grant in IDLE (store > D fill > I fill); no preemption after grant.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (d_wr_req) begin
          state_d = ARB_DWRITE;
        end else if (d_miss) begin
          state_d = ARB_DFILL;
          base_d  = {d_miss_addr[ADDR_W-1:BLK_OFFSET_BITS], {BLK_OFFSET_BITS{1'b0}}};
        end else if (i_miss) begin
          state_d = ARB_IFILL;
          base_d  = {i_miss_addr[ADDR_W-1:BLK_OFFSET_BITS], {BLK_OFFSET_BITS{1'b0}}};
        end
      end
      ARB_DWRITE: state_d = ARB_IDLE;
      ARB_DFILL, ARB_IFILL: begin
        if (ret_fire && ret_last) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Memory and fill-return outputs decoded from the registered state.
  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_data    = '0;
    fill_word    = '0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    i_fill_done  = 1'b0;
    d_fill_done  = 1'b0;
    d_wr_ack     = 1'b0;
    if (state_q == ARB_DWRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = d_wr_addr;
      mem_wdata = d_wr_data;
      d_wr_ack  = 1'b1;
    end
    if (in_fill) begin
      if (!issue_done) begin
        mem_en   = 1'b1;
        mem_addr = base_q + word_offset;
      end
      if (mem_rvalid) begin
        fill_data    = mem_rdata;
        fill_word    = ret_cnt;
        i_fill_valid = (state_q == ARB_IFILL);
        d_fill_valid = (state_q == ARB_DFILL);
        i_fill_done  = (state_q == ARB_IFILL) && ret_last;
        d_fill_done  = (state_q == ARB_DFILL) && ret_last;
      end
    end
  end

  // State and block-base registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter against a transaction-level timing model.
module tb_cache_mem_arbiter;
  import cache_pkg::*;

  localparam int NumCycles = 3000;
  localparam int Lat       = int'(MEM_LAT);
  localparam int Words     = int'(WORDS_PER_BLK);
  localparam int FillLen   = Lat + Words;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] fill_data;
  logic        i_fill_valid, d_fill_valid, i_fill_done, d_fill_done, d_wr_ack, busy;
  logic [2:0]  fill_word;

  always #5 clk = ~clk;

  cache_mem_arbiter #(
    .ADDR_W(16),
    .DATA_W(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_miss      (i_miss),
    .i_miss_addr (i_miss_addr),
    .d_miss      (d_miss),
    .d_miss_addr (d_miss_addr),
    .d_wr_req    (d_wr_req),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .fill_data   (fill_data),
    .i_fill_valid(i_fill_valid),
    .d_fill_valid(d_fill_valid),
    .fill_word   (fill_word),
    .i_fill_done (i_fill_done),
    .d_fill_done (d_fill_done),
    .d_wr_ack    (d_wr_ack),
    .busy        (busy)
  );

  // Model: which transaction owns memory and how many cycles since its grant.
  typedef enum int {KIdle, KWrite, KDFill, KIFill} kind_e;
  kind_e       m_kind = KIdle;
  int          m_t = 0;
  logic [15:0] m_base = '0;
  logic        rel_w, rel_d, rel_i;

  // Memory: default word value equals its address; stores overwrite it.
  logic [15:0] mem_store [logic [15:0]];
  typedef struct {int due; logic [15:0] data;} ret_t;
  ret_t rq[$];

  int cyc = 0, n_checks = 0, n_errors = 0, quiet = 0, n_resets = 0, n_done_seen = 0;

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Advance the model across a clock edge using the inputs held in the last cycle.
  task automatic step_model();
    rel_w = 1'b0;
    rel_d = 1'b0;
    rel_i = 1'b0;
    if (!rst_n) begin
      m_kind = KIdle;
      m_t    = 0;
    end else begin
      case (m_kind)
        KIdle: begin
          if (d_wr_req) begin
            m_kind = KWrite;
            m_t    = 1;
          end else if (d_miss) begin
            m_kind = KDFill;
            m_base = d_miss_addr & 16'hFFF0;
            m_t    = 1;
          end else if (i_miss) begin
            m_kind = KIFill;
            m_base = i_miss_addr & 16'hFFF0;
            m_t    = 1;
          end
        end
        KWrite: begin
          m_kind = KIdle;
          m_t    = 0;
          rel_w  = 1'b1;
        end
        default: begin
          if (m_t == FillLen) begin
            if (m_kind == KDFill) rel_d = 1'b1;
            else rel_i = 1'b1;
            m_kind = KIdle;
            m_t    = 0;
          end else begin
            m_t++;
          end
        end
      endcase
    end
  endtask

  task automatic drive_inputs();
    logic [15:0] r;
    if (!rst_n && cyc >= 3) begin
      rst_n    = 1'b1;
      d_wr_req = 1'b0;
      d_miss   = 1'b0;
      i_miss   = 1'b0;
      quiet    = Lat + 2;
    end else if (cyc > 100 && n_resets < 6 &&
                 ((m_kind == KDFill && m_t == 6 && $urandom_range(0, 3) == 0) ||
                  $urandom_range(0, 399) == 0)) begin
      rst_n = 1'b0;
      n_resets++;
    end
    if (rel_w) d_wr_req = 1'b0;
    if (rel_d) d_miss = 1'b0;
    if (rel_i) i_miss = 1'b0;
    if (quiet > 0) quiet--;
    if (cyc == 4) begin
      i_miss      = 1'b1;
      i_miss_addr = 16'h1236;
    end
    if (cyc == 25) begin
      d_wr_req    = 1'b1;
      d_wr_addr   = 16'h0040;
      d_wr_data   = 16'hBEEF;
      d_miss      = 1'b1;
      d_miss_addr = 16'h0102;
      i_miss      = 1'b1;
      i_miss_addr = 16'h2000;
    end
    if (rst_n && quiet == 0 && cyc >= 60) begin
      if (!d_wr_req && $urandom_range(0, 11) == 0) begin
        d_wr_req  = 1'b1;
        d_wr_addr = 16'($urandom) & 16'h83FE;
        d_wr_data = 16'($urandom);
      end
      if (!d_miss && m_kind != KDFill && $urandom_range(0, 9) == 0) begin
        d_miss      = 1'b1;
        d_miss_addr = 16'($urandom) & 16'h83FF;
      end
      if (!i_miss && m_kind != KIFill && $urandom_range(0, 7) == 0) begin
        i_miss      = 1'b1;
        i_miss_addr = 16'($urandom) & 16'h83FF;
      end
      if (m_kind == KDFill && d_miss && $urandom_range(0, 9) == 0) d_miss = 1'b0;
    end
    // Memory return path, with occasional spurious pulses while no fill owns memory.
    r          = 16'($urandom);
    mem_rvalid = 1'b0;
    mem_rdata  = r;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rq[0].data;
      void'(rq.pop_front());
    end else if ((m_kind == KIdle || m_kind == KWrite) && $urandom_range(0, 5) == 0) begin
      mem_rvalid = 1'b1;
    end
  endtask

  task automatic check_outputs();
    logic        fill, issue, ret, wr;
    int          widx;
    logic [15:0] e_addr, e_data;
    fill   = (m_kind == KDFill) || (m_kind == KIFill);
    wr     = (m_kind == KWrite);
    issue  = fill && m_t >= 1 && m_t <= Words;
    ret    = fill && m_t > Lat && m_t <= FillLen;
    widx   = m_t - Lat - 1;
    e_addr = wr ? d_wr_addr : (issue ? m_base + 16'(2 * (m_t - 1)) : 16'h0000);
    e_data = ret ? mem_read(m_base + 16'(2 * widx)) : 16'h0000;
    check("busy",         32'(busy),         32'(m_kind != KIdle));
    check("mem_en",       32'(mem_en),       32'(wr || issue));
    check("mem_wr",       32'(mem_wr),       32'(wr));
    check("mem_addr",     32'(mem_addr),     32'(e_addr));
    check("mem_wdata",    32'(mem_wdata),    32'(wr ? d_wr_data : 16'h0000));
    check("d_wr_ack",     32'(d_wr_ack),     32'(wr));
    check("fill_data",    32'(fill_data),    32'(e_data));
    check("fill_word",    32'(fill_word),    ret ? 32'(widx) : 32'd0);
    check("i_fill_valid", 32'(i_fill_valid), 32'(ret && m_kind == KIFill));
    check("d_fill_valid", 32'(d_fill_valid), 32'(ret && m_kind == KDFill));
    check("i_fill_done",  32'(i_fill_done),  32'(m_kind == KIFill && m_t == FillLen));
    check("d_fill_done",  32'(d_fill_done),  32'(m_kind == KDFill && m_t == FillLen));
    if (i_fill_done || d_fill_done) n_done_seen++;
  endtask

  task automatic capture_memory();
    ret_t e;
    if (mem_en && !mem_wr) begin
      e.due  = cyc + Lat;
      e.data = mem_read(mem_addr);
      rq.push_back(e);
    end
    if (mem_en && mem_wr) mem_store[mem_addr] = mem_wdata;
  endtask

  initial begin
    for (int c = 0; c < NumCycles; c++) begin
      @(posedge clk);
      cyc++;
      step_model();
      #1;
      drive_inputs();
      @(negedge clk);
      check_outputs();
      capture_memory();
    end
    check("fills_completed", 32'(n_done_seen >= 20), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
